// File: rtl/plru_pkg.sv
// Shared types and pure tree-walk functions for the tree pseudo-LRU controller.
// Functions operate on a maximum-width state; callers zero-extend and truncate.
package plru_pkg;

  localparam int unsigned PLRU_MAX_LEVELS = 6;
  localparam int unsigned PLRU_MAX_WAYS   = 1 << PLRU_MAX_LEVELS;

  typedef logic [PLRU_MAX_WAYS-2:0]   plru_state_t;
  typedef logic [PLRU_MAX_LEVELS-1:0] plru_way_t;
  typedef logic [PLRU_MAX_LEVELS-1:0] plru_node_t;

  typedef enum logic {StInit, StRun} plru_fsm_e;
  typedef enum logic {UpdTouch, UpdPoint} plru_mode_e;

  function automatic int unsigned plru_state_bits(input int unsigned assoc);
    return assoc - 1;
  endfunction

  // Follow node bits from the root; bit 0 = left subtree, 1 = right subtree.
  function automatic plru_way_t plru_victim(input plru_state_t state,
                                            input int unsigned levels);
    plru_node_t node;
    plru_way_t  way;
    node = '0;
    way  = '0;
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        way  = {way[PLRU_MAX_LEVELS-2:0], state[node]};
        node = {node[PLRU_MAX_LEVELS-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(state[node]);
      end
    end
    return way;
  endfunction

  // Rewrite every node on the path to 'way': toward=1 points at it, toward=0 away.
  function automatic plru_state_t plru_walk(input plru_state_t state, input plru_way_t way,
                                            input int unsigned levels, input logic toward);
    plru_state_t nxt;
    plru_node_t  node;
    plru_way_t   path;
    logic        b;
    nxt  = state;
    node = '0;
    path = way << (PLRU_MAX_LEVELS - levels);
    for (int unsigned lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        b         = path[PLRU_MAX_LEVELS-1];
        nxt[node] = toward ? b : ~b;
        node      = {node[PLRU_MAX_LEVELS-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(b);
        path      = path << 1;
      end
    end
    return nxt;
  endfunction

  function automatic plru_state_t plru_touch(input plru_state_t state, input plru_way_t way,
                                             input int unsigned levels);
    return plru_walk(state, way, levels, 1'b0);
  endfunction

  function automatic plru_state_t plru_point(input plru_state_t state, input plru_way_t way,
                                             input int unsigned levels);
    return plru_walk(state, way, levels, 1'b1);
  endfunction

endpackage

// File: rtl/plru_tree_update.sv
// Combinational next-state for one PLRU tree: touch (point away from way) on hit/fill,
// point (make way the victim) on invalidate.
module plru_tree_update
  import plru_pkg::*;
#(
  parameter int unsigned ASSOC = 4,
  parameter int unsigned WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0] i_state,
  input  logic [WAY_W-1:0] i_way,
  input  logic             i_mode,
  output logic [ASSOC-2:0] o_state
);

  plru_state_t w_state_ext;
  plru_way_t   w_way_ext;
  plru_state_t w_next;

  always_comb begin
    w_state_ext              = '0;
    w_state_ext[ASSOC-2:0]   = i_state;
    w_way_ext                = '0;
    w_way_ext[WAY_W-1:0]     = i_way;
    if (i_mode == UpdPoint) begin
      w_next = plru_point(w_state_ext, w_way_ext, WAY_W);
    end else begin
      w_next = plru_touch(w_state_ext, w_way_ext, WAY_W);
    end
  end

  assign o_state = w_next[ASSOC-2:0];

  // Bits above this tree's width are always untouched padding.
  if (ASSOC < PLRU_MAX_WAYS) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_next[PLRU_MAX_WAYS-2:ASSOC-1];
  end

endmodule

// File: rtl/plru_tree_ctrl.sv
// Per-set tree pseudo-LRU controller: init sweep, access/invalidate arbitration, victim read.
// Optional macro PLRU_INVALID_FIRST_EN adds valid_mask and prefers the lowest invalid way.
module plru_tree_ctrl
  import plru_pkg::*;
#(
  parameter int unsigned ASSOC    = 4,
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned WAY_W    = $clog2(ASSOC),
  parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic [IDX_W-1:0] lookup_index,
  output logic [WAY_W-1:0] victim_way,
  input  logic             acc_valid,
  input  logic [IDX_W-1:0] acc_index,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             inv_valid,
  output logic             inv_ready,
  input  logic [IDX_W-1:0] inv_index,
  input  logic [WAY_W-1:0] inv_way
`ifdef PLRU_INVALID_FIRST_EN
  ,
  input  logic [ASSOC-1:0] valid_mask
`endif
);

  localparam int unsigned STATE_W = plru_state_bits(ASSOC);

  logic [STATE_W-1:0] r_tree [NUM_SETS];

  plru_fsm_e          r_fsm, w_fsm_next;
  logic [IDX_W-1:0]   r_sweep, w_sweep_next;

  logic               w_we;
  logic [IDX_W-1:0]   w_waddr;
  logic [STATE_W-1:0] w_wdata;

  logic               w_sel_inv;
  logic [IDX_W-1:0]   w_upd_index;
  logic [WAY_W-1:0]   w_upd_way;
  logic               w_upd_mode;
  logic [STATE_W-1:0] w_upd_next;

  // Update operands are muxed outside the FSM block so no comb path loops through it.
  assign w_sel_inv   = ~acc_valid;
  assign w_upd_index = w_sel_inv ? inv_index : acc_index;
  assign w_upd_way   = w_sel_inv ? inv_way : acc_way;
  assign w_upd_mode  = w_sel_inv ? UpdPoint : UpdTouch;

  plru_tree_update #(
    .ASSOC (ASSOC),
    .WAY_W (WAY_W)
  ) u_update (
    .i_state (r_tree[w_upd_index]),
    .i_way   (w_upd_way),
    .i_mode  (w_upd_mode),
    .o_state (w_upd_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= StInit;
      r_sweep <= '0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_sweep <= w_sweep_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_sweep_next = r_sweep;
    ready        = 1'b0;
    inv_ready    = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_sweep;
    w_wdata      = '0;
    unique case (r_fsm)
      StInit: begin
        w_we         = 1'b1;
        w_sweep_next = r_sweep + 1'b1;
        if (r_sweep == IDX_W'(NUM_SETS - 1)) begin
          w_fsm_next = StRun;
        end
      end
      StRun: begin
        ready     = 1'b1;
        inv_ready = ~acc_valid;
        if (acc_valid || inv_valid) begin
          w_we    = 1'b1;
          w_waddr = w_upd_index;
          w_wdata = w_upd_next;
        end
      end
      default: w_fsm_next = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_tree[w_waddr] <= w_wdata;
    end
  end

  plru_state_t w_lookup_ext;
  plru_way_t   w_victim_ext;
  logic [WAY_W-1:0] w_tree_victim;

  always_comb begin
    w_lookup_ext              = '0;
    w_lookup_ext[STATE_W-1:0] = r_tree[lookup_index];
    w_victim_ext              = plru_victim(w_lookup_ext, WAY_W);
  end

  assign w_tree_victim = w_victim_ext[WAY_W-1:0];

  if (WAY_W < PLRU_MAX_LEVELS) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_victim_ext[PLRU_MAX_LEVELS-1:WAY_W];
  end

`ifdef PLRU_INVALID_FIRST_EN
  // Descending scan so the lowest-numbered invalid way is the last to assign.
  always_comb begin
    victim_way = w_tree_victim;
    for (int i = int'(ASSOC) - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        victim_way = WAY_W'(i);
      end
    end
  end
`else
  assign victim_way = w_tree_victim;
`endif

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// Directed self-checking bench for plru_tree_ctrl with ASSOC=4, NUM_SETS=8.
module tb_plru_tree_ctrl;

  localparam int unsigned ASSOC    = 4;
  localparam int unsigned NUM_SETS = 8;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned IDX_W    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [IDX_W-1:0] lookup_index;
  logic [WAY_W-1:0] victim_way;
  logic             acc_valid;
  logic [IDX_W-1:0] acc_index;
  logic [WAY_W-1:0] acc_way;
  logic             inv_valid;
  logic             inv_ready;
  logic [IDX_W-1:0] inv_index;
  logic [WAY_W-1:0] inv_way;
  logic [ASSOC-1:0] valid_mask;

  int checks   = 0;
  int failures = 0;

  plru_tree_ctrl #(
    .ASSOC    (ASSOC),
    .NUM_SETS (NUM_SETS),
    .WAY_W    (WAY_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .lookup_index (lookup_index),
    .victim_way   (victim_way),
    .acc_valid    (acc_valid),
    .acc_index    (acc_index),
    .acc_way      (acc_way),
    .inv_valid    (inv_valid),
    .inv_ready    (inv_ready),
    .inv_index    (inv_index),
    .inv_way      (inv_way)
`ifdef PLRU_INVALID_FIRST_EN
    ,
    .valid_mask   (valid_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input int set, input int exp);
    lookup_index = IDX_W'(set);
    #1;
    check(tag, 32'(victim_way), 32'(exp));
  endtask

  initial begin
    rst          = 1'b1;
    lookup_index = '0;
    acc_valid    = 1'b0;
    acc_index    = '0;
    acc_way      = '0;
    inv_valid    = 1'b0;
    inv_index    = '0;
    inv_way      = '0;
    valid_mask   = '1;

    step();
    step();
    check("reset_ready", 32'(ready), 0);
    check("reset_inv_ready", 32'(inv_ready), 0);

    rst = 1'b0;
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      step();
      check($sformatf("sweep_ready_%0d", i), 32'(ready), (i == int'(NUM_SETS) - 1) ? 1 : 0);
    end
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      look($sformatf("init_victim_set%0d", s), s, 0);
    end

    // Access way 0 then way 2 in set 3; the lookup shows pre-update state meanwhile.
    acc_valid = 1'b1;
    acc_index = 3'd3;
    acc_way   = 2'd0;
    look("same_cycle_pre_update", 3, 0);
    step();
    acc_way = 2'd2;
    step();
    acc_valid = 1'b0;
    look("acc_set3_victim", 3, 1);
    look("acc_set4_untouched", 4, 0);

    inv_valid = 1'b1;
    inv_index = 3'd3;
    inv_way   = 2'd3;
    #1;
    check("inv_ready_idle", 32'(inv_ready), 1);
    step();
    inv_valid = 1'b0;
    look("inv_set3_victim", 3, 3);

    // Invalidate on set 5 stalled by three accesses to set 1 way 1.
    inv_valid = 1'b1;
    inv_index = 3'd5;
    inv_way   = 2'd2;
    acc_valid = 1'b1;
    acc_index = 3'd1;
    acc_way   = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_inv_ready_%0d", i), 32'(inv_ready), 0);
      step();
    end
    acc_valid = 1'b0;
    #1;
    check("stall_release_inv_ready", 32'(inv_ready), 1);
    look("stall_set5_not_yet", 5, 0);
    step();
    inv_valid = 1'b0;
    look("stall_set5_applied", 5, 2);
    look("b2b_set1_victim", 1, 2);

    // Mid-run reset; accesses during the sweep must be ignored.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_ready_low", 32'(ready), 0);
    acc_valid = 1'b1;
    acc_index = 3'd0;
    acc_way   = 2'd0;
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      step();
      if (i == int'(NUM_SETS) - 2) acc_valid = 1'b0;
      check($sformatf("resweep_ready_%0d", i), 32'(ready), (i == int'(NUM_SETS) - 1) ? 1 : 0);
    end
    look("resweep_set3", 3, 0);
    look("resweep_set5", 5, 0);
    look("resweep_set0_acc_ignored", 0, 0);

`ifdef PLRU_INVALID_FIRST_EN
    valid_mask = 4'b1011;
    look("if_mask_1011", 0, 2);
    valid_mask = 4'b0111;
    look("if_mask_0111", 0, 3);
    valid_mask = 4'b1111;
    look("if_mask_1111", 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plru_tree_ctrl.md
# plru_tree_ctrl

Parametrised tree pseudo-LRU replacement controller for the set-associative L1 caches. It keeps one registered PLRU tree per set and updates it on every processor hit or fill. It also accepts snoop and coherence invalidations, which make the invalidated way the next victim. The victim way for the current lookup index is presented combinationally to the cache block.

## Interface
Parameters:
- `ASSOC`, default 4: number of ways; a power of 2, at least 2.
- `NUM_SETS`, default 64: number of sets; a power of 2.
- `WAY_W`, default $clog2(ASSOC): width of a way number (derived).
- `IDX_W`, default $clog2(NUM_SETS): width of a set index (derived).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ready`  out  1  high once the init sweep is complete.
- `lookup_index`  in  IDX_W  set being looked up by the processor.
- `victim_way`  out  WAY_W  replacement way for `lookup_index`.
- `acc_valid`  in  1  a hit or fill occurred.
- `acc_index`  in  IDX_W  set of the access.
- `acc_way`  in  WAY_W  way that was accessed.
- `inv_valid`  in  1  invalidate request.
- `inv_ready`  out  1  invalidate accepted this cycle.
- `inv_index`  in  IDX_W  set being invalidated.
- `inv_way`  in  WAY_W  way being invalidated.
- `valid_mask`  in  ASSOC  per-way valid bits of `lookup_index`; present only with `PLRU_INVALID_FIRST_EN`.

## Operation
- State per set: ASSOC-1 tree bits, stored in one array with one write per cycle.
  - Node 0 is the root; node i has children 2i+1 and 2i+2; the leaves map to ways 0..ASSOC-1 from left to right.
  - A node bit of 0 means the victim lies in the left subtree; 1 means the right subtree.
- Victim: walk from the root following the node bits; the leaf reached is `victim_way`.
- Access update: every node on the path to `acc_way` is set to point away from it. Nodes off the path are unchanged.
- Invalidate update: every node on the path to `inv_way` is set to point toward it.
- FSM:
  - INIT: a counter sweeps sets 0..NUM_SETS-1, writing all-zero state, one set per cycle. `ready`=0. `acc_valid` and `inv_valid` are ignored.
  - After the last set is written, the FSM moves to RUN with `ready`=1.
  - RUN has no exit except `rst`.
- Write arbitration in RUN:
  - An access always wins: `inv_ready` = `ready` & !`acc_valid`.
  - An invalidate is performed only in a cycle where `inv_valid` & `inv_ready`.
  - The requester holds `inv_valid`, `inv_index` and `inv_way` stable until accepted.
- Arithmetic: all index and way fields are unsigned. Out-of-range values cannot occur because widths are exact powers of 2.

## Timing
- Reset values: `ready`=0; `inv_ready`=0; sweep counter=0; FSM=INIT. `victim_way` reads 0 for any set that has already been swept.
- `rst` asserted mid-operation returns the FSM to INIT on the next edge and restarts the sweep from set 0.
- `ready` rises NUM_SETS cycles after the first edge with `rst` low.
- `victim_way` is combinational from `lookup_index` and the stored state. It does not bypass updates.
- An access or invalidate at edge N is visible on `victim_way` from edge N+1.
- Same-set lookup and access in one cycle: `victim_way` shows the pre-update state.
- Back-to-back accesses to the same set are all applied, in cycle order.
- A continuous stream of `acc_valid` stalls invalidates indefinitely. The bus side is required to tolerate this.

## Configuration
- `PLRU_INVALID_FIRST_EN` defined:
  - The `valid_mask` port exists.
  - If any bit of `valid_mask` is 0, `victim_way` is the lowest-numbered invalid way.
  - If all bits are 1, `victim_way` is the tree result.
- `PLRU_INVALID_FIRST_EN` undefined: no `valid_mask` port, and `victim_way` is always the tree result.

## Structure
- Shared package `plru_pkg`:
  - `plru_state_t` sizing function: ASSOC-1 bits.
  - FSM state enum: INIT, RUN.
  - Pure functions `plru_victim(state)`, `plru_touch(state, way)` and `plru_point(state, way)`.
- Natural sub-module: `plru_tree_update`, combinational, taking the current state, a way and a mode (touch or point) and returning the next state.
- Top level holds the state array, the FSM, the sweep counter and the arbitration.

## Test plan
All scenarios use ASSOC=4, NUM_SETS=8.
- Reset, then release → `ready`=0 for 8 cycles, then 1. `victim_way`=0 for every set.
- Access way 0, then way 2, in set 3 → set 3 `victim_way`=1; set 4 `victim_way`=0.
- After the previous scenario, invalidate way 3 in set 3 while `acc_valid`=0 → `inv_ready`=1. The next cycle set 3 `victim_way`=3.
- `inv_valid` held on set 5 while `acc_valid` is high for 3 cycles → `inv_ready`=0 for those 3 cycles. The invalidate is applied on the 4th cycle.
- Assert `rst` for 1 cycle mid-run after the accesses above → sweep restarts; after 8 cycles set 3 `victim_way`=0.
- With `PLRU_INVALID_FIRST_EN`, `valid_mask`=4'b1011 and tree victim 0 → `victim_way`=2. With `valid_mask`=4'b1111 → `victim_way`=0.
